bitcmd_sequencer: RTL and testbench
===================================

// Module: bitcmd_sequencer
// PURPOSE
//  Command-issuing (initiator) end of the 4-bit set/clear register protocol.
//  Each protocol command is {set/clear, bit index}; the remote bit register updates one bit per accepted command.
//  Takes a target bit pattern and emits the minimal command sequence to move the remote register to it.
//  Keeps a local mirror of the remote register contents. Sits between control logic and the bit-register state machine.
// PARAMETERS
//  WIDTH  4                  number of register bits (remote state space 2**WIDTH)
//  IDXW   $clog2(WIDTH)      width of command bit index (derived, do not override)
//  CNTW   $clog2(WIDTH+1)    width of per-transaction command counter (derived)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  tgt_valid  in   1      target pattern offered
//  tgt_ready  out  1      sequencer can accept a target (IDLE only)
//  tgt_data   in   WIDTH  requested final register pattern
//  cmd_valid  out  1      command presented to remote register
//  cmd_ready  in   1      remote accepts command this cycle
//  cmd_set    out  1      1 = set bit, 0 = clear bit
//  cmd_idx    out  IDXW   bit index addressed by the command
//  mirror     out  WIDTH  local copy of remote register contents
//  busy       out  1      transaction in progress (state != IDLE)
//  done       out  1      one-cycle pulse: transaction complete
//  cmd_count  out  CNTW   commands issued in last/current transaction
// BEHAVIOUR
//  Reset: state=IDLE, mirror=0 (matches remote reset state), tgt_q=0, cmd_count=0;
//   tgt_ready=1, cmd_valid=0, cmd_set=0, cmd_idx=0, busy=0, done=0.
//  FSM states: IDLE, ISSUE, DONE.
//  IDLE: tgt_ready=1. If tgt_valid: tgt_q<=tgt_data, cmd_count<=0, go ISSUE.
//  ISSUE: diff = tgt_q ^ mirror.
//   - diff==0: go DONE, cmd_valid=0.
//   - diff!=0: cmd_valid=1, cmd_idx = lowest set bit of diff, cmd_set = tgt_q[cmd_idx].
//   - On cmd_valid & cmd_ready: mirror[cmd_idx]<=cmd_set, cmd_count<=cmd_count+1, stay ISSUE.
//  DONE: done=1 for exactly this cycle; go IDLE. tgt_ready=0 in DONE.
//  Commands decode from registered state only: no combinational path cmd_ready->cmd_valid/idx/set.
//  Handshake: cmd_valid, cmd_set and cmd_idx hold stable while cmd_ready=0 (mirror unchanged).
//  Throughput: one command per cycle when cmd_ready held high.
//  Ordering: differing bits are issued in ascending index order.
//  Count: cmd_count = popcount(tgt_data ^ mirror at accept); never exceeds WIDTH. Holds its value until the next accept.
//  Latency: accept at cycle 0; first command valid cycle 1.
//   With N differing bits and no backpressure, done asserts at cycle N+1.
//  Equal target (N=0): no commands, done at cycle 1, mirror unchanged.
//  tgt_valid outside IDLE: ignored (tgt_ready=0), nothing latched.
//  Reset mid-transaction: return to reset values next edge; outstanding command dropped.
//   The remote register is reset by the same rst, so the mirror stays consistent.
//  cmd_ready while cmd_valid=0: no effect.
// TESTING
//  1 reset, tgt 4'b1011 (cmd_ready=1) -> cmds (set,0),(set,1),(set,3) cycles 1-3; done cycle 4; mirror=1011; cmd_count=3.
//  2 from mirror 1011, tgt 4'b0110 -> (clr,0),(set,2),(clr,3); bit1 untouched; mirror=0110; cmd_count=3.
//  3 tgt equal to mirror (0110) -> cmd_valid never high; done 1 cycle after accept; cmd_count=0.
//  4 tgt 4'b1111 from 0000, cmd_ready low 3 cycles on 2nd cmd -> (set,1) held stable; mirror stays 0001; then resumes.
//  5 tgt_valid pulsed while busy -> tgt_ready=0, no latch; rst in ISSUE -> next cycle mirror=0, cmd_valid=0, IDLE.
//  6 scoreboard: model remote register from accepted commands; equals mirror every cycle over 200 random targets.

Source files
------------

// File: rtl/bitcmd_sequencer.sv
// Initiator for the set/clear bit-register protocol: turns a target pattern into
// the minimal ascending-index command sequence, tracking the remote contents in a mirror.
module bitcmd_sequencer #(
   parameter int unsigned WIDTH = 4,
   localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int unsigned CNTW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic             cmd_set,
   output logic [IDXW-1:0]  cmd_idx,
   output logic [WIDTH-1:0] mirror,
   output logic             busy,
   output logic             done,
   output logic [CNTW-1:0]  cmd_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] mirror_q;
   logic [CNTW-1:0]  cnt_q;
   logic             valid_q;
   logic             set_q;
   logic [IDXW-1:0]  idx_q;
   logic             done_q;

   logic [WIDTH-1:0] acc_diff;
   logic [WIDTH-1:0] mirror_d;
   logic [WIDTH-1:0] rem_diff;
   logic [IDXW-1:0]  acc_idx;
   logic [IDXW-1:0]  rem_idx;
   logic             fire;

   function automatic logic [IDXW-1:0] lowest_idx(input logic [WIDTH-1:0] v);
      logic [IDXW-1:0] r;
      logic            found;
      r     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (v[i] && !found) begin
            r     = IDXW'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // The next command is chosen from the post-update mirror, so the cycle after the
   // last accepted command is already DONE and back-to-back commands need no bubble.
   always_comb begin
      acc_diff          = tgt_data ^ mirror_q;
      acc_idx           = lowest_idx(acc_diff);
      mirror_d          = mirror_q;
      mirror_d[idx_q]   = set_q;
      rem_diff          = tgt_q ^ mirror_d;
      rem_idx           = lowest_idx(rem_diff);
      fire              = valid_q & cmd_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tgt_q    <= '0;
         mirror_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         set_q    <= 1'b0;
         idx_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (tgt_valid) begin
                  tgt_q <= tgt_data;
                  cnt_q <= '0;
                  if (acc_diff == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ISSUE;
                     valid_q <= 1'b1;
                     idx_q   <= acc_idx;
                     set_q   <= tgt_data[acc_idx];
                  end
               end
            end
            S_ISSUE: begin
               if (fire) begin
                  mirror_q <= mirror_d;
                  cnt_q    <= cnt_q + 1'b1;
                  if (rem_diff == '0) begin
                     valid_q <= 1'b0;
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= rem_idx;
                     set_q <= tgt_q[rem_idx];
                  end
               end else if (!valid_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tgt_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign cmd_valid = valid_q;
   assign cmd_set   = set_q;
   assign cmd_idx   = idx_q;
   assign mirror    = mirror_q;
   assign done      = done_q;
   assign cmd_count = cnt_q;

endmodule

// File: tb/tb_bitcmd_sequencer.sv
// Bench for bitcmd_sequencer: directed transactions plus random targets, checked against
// a remote-register scoreboard and a per-target expected command list.
module tb_bitcmd_sequencer;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             tgt_valid;
   logic             tgt_ready;
   logic [WIDTH-1:0] tgt_data;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_set;
   logic [1:0]       cmd_idx;
   logic [WIDTH-1:0] mirror;
   logic             busy;
   logic             done;
   logic [2:0]       cmd_count;

   always #5 clk = ~clk;

   bitcmd_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .tgt_data  (tgt_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_set   (cmd_set),
      .cmd_idx   (cmd_idx),
      .mirror    (mirror),
      .busy      (busy),
      .done      (done),
      .cmd_count (cmd_count)
   );

   int checks = 0;
   int errors = 0;

   // Scoreboard: remote register as built from accepted commands, plus the expected
   // {set, idx} sequence for the current target.
   logic [WIDTH-1:0] remote = '0;
   logic [2:0]       exp_q[$];
   logic             stalled_prev = 1'b0;
   logic [2:0]       prev_cmd = '0;

   logic             s_valid, s_set, s_busy, s_done, s_rdy;
   logic [1:0]       s_idx;
   logic [WIDTH-1:0] s_mirror;
   logic [2:0]       s_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic monitor();
      logic [2:0] e;
      s_valid  = cmd_valid;
      s_set    = cmd_set;
      s_idx    = cmd_idx;
      s_mirror = mirror;
      s_busy   = busy;
      s_done   = done;
      s_rdy    = tgt_ready;
      s_cnt    = cmd_count;
      check_eq("mirror_vs_remote", mirror, remote);
      if (stalled_prev) begin
         check_eq("hold_valid", cmd_valid, 1);
         check_eq("hold_cmd", {cmd_set, cmd_idx}, prev_cmd);
      end
      if (!rst && cmd_valid && cmd_ready) begin
         check_eq("cmd_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("cmd", {cmd_set, cmd_idx}, e);
         end
         remote[cmd_idx] = cmd_set;
      end
      stalled_prev = !rst && cmd_valid && !cmd_ready;
      prev_cmd     = {cmd_set, cmd_idx};
      if (rst) begin
         remote = '0;
         exp_q.delete();
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [WIDTH-1:0] tgt, input bit rnd, input int stall_at);
      int n;
      int k;
      bit seen;
      k = 0;
      while (!tgt_ready && k < 10) begin
         cyc();
         k++;
      end
      check_eq("ready_wait", tgt_ready, 1);
      exp_q.delete();
      n = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (tgt[i] != remote[i]) begin
            exp_q.push_back({tgt[i], 2'(i)});
            n++;
         end
      end
      tgt_valid = 1'b1;
      tgt_data  = tgt;
      cmd_ready = 1'($urandom);
      cyc();
      tgt_valid = 1'b0;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 60) begin
         k++;
         if (rnd) cmd_ready = ($urandom_range(3) != 0);
         else     cmd_ready = !(stall_at != 0 && k >= stall_at && k < stall_at + 3);
         tgt_valid = rnd ? 1'($urandom_range(1)) : 1'b0;
         tgt_data  = 4'($urandom);
         cyc();
         check_eq("rdy_busy", s_rdy, 0);
         seen = s_done;
      end
      tgt_valid = 1'b0;
      check_eq("done_seen", seen, 1);
      if (!rnd) check_eq("latency", k, n + 1 + ((stall_at != 0) ? 3 : 0));
      check_eq("busy_in_done", s_busy, 1);
      check_eq("count", s_cnt, n);
      check_eq("final_mirror", s_mirror, tgt);
      check_eq("cmds_left", exp_q.size(), 0);
      cmd_ready = 1'($urandom);
      cyc();
      check_eq("done_pulse", s_done, 0);
      check_eq("idle_ready", s_rdy, 1);
      check_eq("idle_busy", s_busy, 0);
      check_eq("count_hold", s_cnt, n);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      tgt_valid = 1'b0;
      tgt_data  = '0;
      cmd_ready = 1'b0;
      @(posedge clk);
      #1;
      cyc();
      tgt_valid = 1'b1;
      tgt_data  = 4'b1111;
      cmd_ready = 1'b1;
      cyc();
      check_eq("rst_ready", s_rdy, 1);
      check_eq("rst_valid", s_valid, 0);
      check_eq("rst_set", s_set, 0);
      check_eq("rst_idx", s_idx, 0);
      check_eq("rst_busy", s_busy, 0);
      check_eq("rst_done", s_done, 0);
      check_eq("rst_mirror", s_mirror, 0);
      check_eq("rst_count", s_cnt, 0);
      tgt_valid = 1'b0;
      rst       = 1'b0;

      run_txn(4'b1011, 1'b0, 0);
      run_txn(4'b0110, 1'b0, 0);
      run_txn(4'b0110, 1'b0, 0);
      run_txn(4'b0000, 1'b0, 0);
      run_txn(4'b1111, 1'b0, 2);

      // Reset while a command is stalled in ISSUE.
      tgt_valid = 1'b1;
      tgt_data  = 4'b0000;
      cmd_ready = 1'b0;
      cyc();
      tgt_valid = 1'b0;
      cyc();
      check_eq("pre_rst_valid", s_valid, 1);
      check_eq("pre_rst_busy", s_busy, 1);
      rst = 1'b1;
      cyc();
      rst       = 1'b0;
      cmd_ready = 1'b1;
      cyc();
      check_eq("mid_rst_mirror", s_mirror, 0);
      check_eq("mid_rst_valid", s_valid, 0);
      check_eq("mid_rst_ready", s_rdy, 1);
      check_eq("mid_rst_busy", s_busy, 0);
      check_eq("mid_rst_count", s_cnt, 0);

      for (int t = 0; t < 200; t++) begin
         run_txn(4'($urandom), (t % 4) != 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
